pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 40 ++++
 rtl/pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard/stall control bundle between the pipeline and pipe_ctrl.
// master drives pipeline status, slave is the controller.
interface pipe_ctrl_if #(
    parameter int MC_CNT_W = 6,
    parameter int STAT_W   = 16
);
    logic                id_reg1_read_i;
    logic [4:0]          id_reg1_addr_i;
    logic                id_reg2_read_i;
    logic [4:0]          id_reg2_addr_i;
    logic                ex_is_load_i;
    logic                ex_wreg_i;
    logic [4:0]          ex_wd_i;
    logic                mc_start_i;
    logic [MC_CNT_W-1:0] mc_cycles_i;
    logic                flush_i;
    logic [5:0]          stall_o;
    logic                load_use_o;
    logic                mc_busy_o;
    logic                mc_done_o;
    logic [STAT_W-1:0]   stall_cnt_o;

    modport master (
        output id_reg1_read_i, id_reg1_addr_i,
        output id_reg2_read_i, id_reg2_addr_i,
        output ex_is_load_i, ex_wreg_i, ex_wd_i,
        output mc_start_i, mc_cycles_i, flush_i,
        input  stall_o, load_use_o, mc_busy_o,
        input  mc_done_o, stall_cnt_o
    );

    modport slave (
        input  id_reg1_read_i, id_reg1_addr_i,
        input  id_reg2_read_i, id_reg2_addr_i,
        input  ex_is_load_i, ex_wreg_i, ex_wd_i,
        input  mc_start_i, mc_cycles_i, flush_i,
        output stall_o, load_use_o, mc_busy_o,
        output mc_done_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: load-use detection, multi-cycle
// sequencer (IDLE/BUSY/DONE) and a saturating stall counter.
module pipe_ctrl #(
    parameter int MC_CNT_W = 6,
    parameter int STAT_W   = 16
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [STAT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic       load_use;
    logic       start_ok;
    logic       ex_stall;
    logic [5:0] stall_raw;
    logic [5:0] stall;

    // Hazard detection and stall vector priority: flush > ex > load-use.
    always_comb begin
        load_use = bus.ex_is_load_i & bus.ex_wreg_i
                 & (bus.ex_wd_i != 5'd0)
                 & ((bus.id_reg1_read_i
                     & (bus.id_reg1_addr_i == bus.ex_wd_i))
                  | (bus.id_reg2_read_i
                     & (bus.id_reg2_addr_i == bus.ex_wd_i)));
        start_ok = (state_q == S_IDLE) & bus.mc_start_i
                 & (bus.mc_cycles_i != '0);
        ex_stall = start_ok | (state_q == S_BUSY);
        stall_raw = 6'b000000;
        if (bus.flush_i) begin
            stall_raw = 6'b000000;
        end else if (ex_stall) begin
            stall_raw = 6'b001111;
        end else if (load_use) begin
            stall_raw = 6'b000111;
        end
        stall = rst ? stall_raw : 6'b000000;
    end

    // Sequencer next state; a flush aborts any operation in flight.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_d = S_BUSY;
                        cnt_d   = bus.mc_cycles_i;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == MC_CNT_W'(1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - MC_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d == S_BUSY);
        done_d = (state_d == S_DONE);
    end

    // Stall statistics saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall != 6'b000000) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    // State, counter and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs are held low while reset is asserted.
    always_comb begin
        bus.stall_o     = stall;
        bus.load_use_o  = rst & load_use;
        bus.mc_busy_o   = rst & busy_q;
        bus.mc_done_o   = rst & done_q;
        bus.stall_cnt_o = stall_cnt_q;
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: timeline reference model,
// directed scenarios with literal expectations, random traffic.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       r1, r2, ld, wr, st, fl;
    logic [4:0] a1, a2, wd;
    logic [5:0] n;

    pipe_ctrl_if #(.MC_CNT_W(6), .STAT_W(16)) b16 ();
    pipe_ctrl_if #(.MC_CNT_W(6), .STAT_W(4))  b4 ();

    assign b16.id_reg1_read_i = r1;
    assign b16.id_reg1_addr_i = a1;
    assign b16.id_reg2_read_i = r2;
    assign b16.id_reg2_addr_i = a2;
    assign b16.ex_is_load_i   = ld;
    assign b16.ex_wreg_i      = wr;
    assign b16.ex_wd_i        = wd;
    assign b16.mc_start_i     = st;
    assign b16.mc_cycles_i    = n;
    assign b16.flush_i        = fl;
    assign b4.id_reg1_read_i  = r1;
    assign b4.id_reg1_addr_i  = a1;
    assign b4.id_reg2_read_i  = r2;
    assign b4.id_reg2_addr_i  = a2;
    assign b4.ex_is_load_i    = ld;
    assign b4.ex_wreg_i       = wr;
    assign b4.ex_wd_i         = wd;
    assign b4.mc_start_i      = st;
    assign b4.mc_cycles_i     = n;
    assign b4.flush_i         = fl;

    pipe_ctrl #(.MC_CNT_W(6), .STAT_W(16)) u16 (
        .clk(clk), .rst(rst), .bus(b16.slave)
    );
    pipe_ctrl #(.MC_CNT_W(6), .STAT_W(4)) u4 (
        .clk(clk), .rst(rst), .bus(b4.slave)
    );

    int total = 0;
    int bad   = 0;

    // model: an accepted start at cycle ts with length tn means
    // BUSY during (ts, ts+tn] and DONE at ts+tn+1
    int cyc = 0;
    int ts  = 0;
    int tn  = 0;
    bit act = 1'b0;
    int m16 = 0;
    int m4  = 0;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, a, e);
        end
    endtask

    task automatic tick();
        bit in_busy, in_done, idle, lu, exs, acc;
        logic [5:0] es;
        #1;
        in_busy = act && (cyc > ts) && (cyc <= ts + tn);
        in_done = act && (cyc == ts + tn + 1);
        idle    = !in_busy && !in_done;
        lu = ld && wr && (wd != 0)
          && ((r1 && a1 == wd) || (r2 && a2 == wd));
        acc = idle && st && (n != 0);
        exs = acc || in_busy;
        if (!rst || fl) es = 6'd0;
        else if (exs)   es = 6'h0f;
        else if (lu)    es = 6'h07;
        else            es = 6'd0;
        chk("stall16", 32'(b16.stall_o), 32'(es));
        chk("stall4", 32'(b4.stall_o), 32'(es));
        chk("load_use", 32'(b16.load_use_o), 32'(rst && lu));
        chk("busy", 32'(b16.mc_busy_o), 32'(rst && in_busy));
        chk("done", 32'(b16.mc_done_o), 32'(rst && in_done));
        chk("cnt16", 32'(b16.stall_cnt_o), 32'(m16));
        chk("cnt4", 32'(b4.stall_cnt_o), 32'(m4));
        if (!rst) begin
            act = 1'b0;
            m16 = 0;
            m4  = 0;
        end else begin
            if (es != 0) begin
                if (m16 < 65535) m16++;
                if (m4 < 15)     m4++;
            end
            if (fl) begin
                act = 1'b0;
            end else if (acc) begin
                act = 1'b1;
                ts  = cyc;
                tn  = int'(n);
            end else if (in_done) begin
                act = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        r1 = 0; r2 = 0; a1 = 0; a2 = 0;
        ld = 0; wr = 0; wd = 0;
        st = 0; n = 0; fl = 0;
    endtask

    task automatic lu_on();
        ld = 1; wr = 1; wd = 5; r2 = 1; a2 = 5;
    endtask

    initial begin
        rst = 0;
        quiet();
        adv();
        tick();
        chk("rst_stall", 32'(b16.stall_o), 32'h0);
        chk("rst_cnt", 32'(b16.stall_cnt_o), 32'h0);
        adv();
        rst = 1;

        lu_on();
        tick();
        chk("lu_hit", 32'(b16.load_use_o), 32'h1);
        chk("lu_stall", 32'(b16.stall_o), 32'h07);
        adv();
        wd = 0; a2 = 0;
        tick();
        chk("lu_r0", 32'(b16.stall_o), 32'h0);
        adv();
        quiet();

        st = 1; n = 3;
        tick();
        chk("n3_t0_stall", 32'(b16.stall_o), 32'h0f);
        chk("n3_t0_busy", 32'(b16.mc_busy_o), 32'h0);
        adv();
        st = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("n3_stall", 32'(b16.stall_o), 32'h0f);
            chk("n3_busy", 32'(b16.mc_busy_o), 32'h1);
            adv();
        end
        tick();
        chk("n3_done", 32'(b16.mc_done_o), 32'h1);
        chk("n3_done_stall", 32'(b16.stall_o), 32'h0);
        adv();
        tick();
        chk("n3_after", 32'(b16.mc_done_o), 32'h0);
        adv();

        st = 1; n = 2;
        tick();
        adv();
        n = 7;
        lu_on();
        tick();
        chk("prio_stall", 32'(b16.stall_o), 32'h0f);
        adv();
        quiet();
        tick();
        chk("restart_busy", 32'(b16.mc_busy_o), 32'h1);
        adv();
        tick();
        chk("restart_done", 32'(b16.mc_done_o), 32'h1);
        adv();
        tick();
        chk("restart_idle", 32'(b16.mc_busy_o), 32'h0);
        adv();

        st = 1; n = 5;
        tick();
        adv();
        st = 0;
        tick();
        adv();
        fl = 1;
        tick();
        chk("flush_stall", 32'(b16.stall_o), 32'h0);
        adv();
        fl = 0;
        tick();
        chk("flush_idle", 32'(b16.mc_busy_o), 32'h0);
        adv();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("flush_nodone", 32'(b16.mc_done_o), 32'h0);
            adv();
        end
        st = 1; n = 0;
        tick();
        chk("n0_stall", 32'(b16.stall_o), 32'h0);
        adv();
        st = 0;
        tick();
        chk("n0_busy", 32'(b16.mc_busy_o), 32'h0);
        adv();
        st = 1; n = 3; fl = 1;
        tick();
        adv();
        quiet();
        tick();
        chk("flush_nostart", 32'(b16.mc_busy_o), 32'h0);
        adv();

        rst = 0;
        tick();
        adv();
        rst = 1;
        lu_on();
        for (int i = 0; i < 20; i++) begin
            tick();
            adv();
        end
        tick();
        chk("sat4", 32'(b4.stall_cnt_o), 32'hf);
        adv();
        rst = 0;
        tick();
        adv();
        tick();
        chk("sat4_clr", 32'(b4.stall_cnt_o), 32'h0);
        chk("cnt16_clr", 32'(b16.stall_cnt_o), 32'h0);
        adv();
        rst = 1;
        quiet();

        st = 1; n = 10;
        tick();
        adv();
        st = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            adv();
        end
        rst = 0; st = 1; lu_on();
        tick();
        chk("rb_busy", 32'(b16.mc_busy_o), 32'h0);
        chk("rb_stall", 32'(b16.stall_o), 32'h0);
        chk("rb_lu", 32'(b16.load_use_o), 32'h0);
        adv();
        tick();
        adv();
        rst = 1;
        quiet();
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("rb_nodone", 32'(b16.mc_done_o), 32'h0);
            adv();
        end

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(63) != 0);
            r1 = 1'($urandom);
            r2 = 1'($urandom);
            a1 = 5'($urandom_range(3));
            a2 = 5'($urandom_range(3));
            ld = ($urandom_range(3) != 0);
            wr = ($urandom_range(3) != 0);
            wd = 5'($urandom_range(3));
            st = ($urandom_range(3) == 0);
            n  = 6'($urandom_range(7));
            fl = ($urandom_range(15) == 0);
            tick();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
